// File: rtl/regif_alu_fifo.sv
// Register-mapped compute block: operand FIFOs A/B feed a mode-selected ALU into result FIFO Y.
// Optional sticky error register enabled by defining REGIF_ALU_ERR_EN.
module regif_alu_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [ADDR_W-1:0] ADDR_A_NF  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_B_NF  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_Y_NE  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_Y_POP = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_A     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_B     = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] ADDR_ERR   = ADDR_W'(7);

    logic [DATA_W-1:0] a_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] b_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] y_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  a_wr_q, a_rd_q, b_wr_q, b_rd_q, y_wr_q, y_rd_q;
    logic [CNT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, y_cnt_q, y_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              rdy_q;
    logic [DATA_W-1:0] read_data_q, rd_val_s, result_s;

    logic wr_acc_s, rd_acc_s;
    logic a_full_s, b_full_s, y_full_s, a_empty_s, b_empty_s, y_empty_s;
    logic a_push_s, b_push_s, y_pop_s, compute_s;

    assign write_rdy = rdy_q;
    assign read_rdy  = rdy_q;
    assign read_data = read_data_q;

    assign wr_acc_s  = write_en & rdy_q;
    assign rd_acc_s  = read_en & rdy_q;
    assign a_full_s  = (a_cnt_q == FULL_CNT);
    assign b_full_s  = (b_cnt_q == FULL_CNT);
    assign y_full_s  = (y_cnt_q == FULL_CNT);
    assign a_empty_s = (a_cnt_q == CNT_W'(0));
    assign b_empty_s = (b_cnt_q == CNT_W'(0));
    assign y_empty_s = (y_cnt_q == CNT_W'(0));

    // Every full/empty decision uses start-of-cycle occupancy, so a same-cycle pop never frees a slot.
    assign a_push_s  = wr_acc_s && (write_address == ADDR_A) && !a_full_s;
    assign b_push_s  = wr_acc_s && (write_address == ADDR_B) && !b_full_s;
    assign y_pop_s   = rd_acc_s && (read_address == ADDR_Y_POP) && !y_empty_s;
    assign compute_s = !a_empty_s && !b_empty_s && !y_full_s;

    // ALU on the FIFO heads using the mode held at the start of the cycle.
    always_comb begin
        result_s = '0;
        case (mode_q)
            2'd0:    result_s = a_mem_q[a_rd_q] | b_mem_q[b_rd_q];
            2'd1:    result_s = a_mem_q[a_rd_q] & b_mem_q[b_rd_q];
            2'd2:    result_s = a_mem_q[a_rd_q] ^ b_mem_q[b_rd_q];
            default: result_s = a_mem_q[a_rd_q] + b_mem_q[b_rd_q];
        endcase
    end

    // Occupancy and mode next-state.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        y_cnt_d = y_cnt_q;
        mode_d  = mode_q;
        if (a_push_s && !compute_s) begin
            a_cnt_d = a_cnt_q + CNT_W'(1);
        end else if (!a_push_s && compute_s) begin
            a_cnt_d = a_cnt_q - CNT_W'(1);
        end else begin
            a_cnt_d = a_cnt_q;
        end
        if (b_push_s && !compute_s) begin
            b_cnt_d = b_cnt_q + CNT_W'(1);
        end else if (!b_push_s && compute_s) begin
            b_cnt_d = b_cnt_q - CNT_W'(1);
        end else begin
            b_cnt_d = b_cnt_q;
        end
        if (compute_s && !y_pop_s) begin
            y_cnt_d = y_cnt_q + CNT_W'(1);
        end else if (!compute_s && y_pop_s) begin
            y_cnt_d = y_cnt_q - CNT_W'(1);
        end else begin
            y_cnt_d = y_cnt_q;
        end
        if (wr_acc_s && (write_address == ADDR_MODE)) begin
            mode_d = write_data[1:0];
        end else begin
            mode_d = mode_q;
        end
    end

`ifdef REGIF_ALU_ERR_EN
    logic [3:0] err_q, err_d, err_ev_s;

    // Sticky error events; a clearing read loses to an event in the same cycle.
    always_comb begin
        err_ev_s    = '0;
        err_ev_s[0] = wr_acc_s && (write_address == ADDR_A) && a_full_s;
        err_ev_s[1] = wr_acc_s && (write_address == ADDR_B) && b_full_s;
        err_ev_s[2] = rd_acc_s && (read_address == ADDR_Y_POP) && y_empty_s;
        err_ev_s[3] = wr_acc_s && (write_address != ADDR_A) && (write_address != ADDR_B)
                      && (write_address != ADDR_MODE);
        if (rd_acc_s && (read_address == ADDR_ERR)) begin
            err_d = err_ev_s;
        end else begin
            err_d = err_q | err_ev_s;
        end
    end

    // Error register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Read-port mux, statuses zero-extended.
    always_comb begin
        rd_val_s = '0;
        case (read_address)
            ADDR_A_NF:  rd_val_s = DATA_W'(!a_full_s);
            ADDR_B_NF:  rd_val_s = DATA_W'(!b_full_s);
            ADDR_Y_NE:  rd_val_s = DATA_W'(!y_empty_s);
            ADDR_Y_POP: rd_val_s = y_empty_s ? '0 : y_mem_q[y_rd_q];
            ADDR_A:     rd_val_s = DATA_W'(y_cnt_q);
            ADDR_MODE:  rd_val_s = DATA_W'(mode_q);
            ADDR_ERR: begin
`ifdef REGIF_ALU_ERR_EN
                rd_val_s = DATA_W'(err_q);
`else
                rd_val_s = '0;
`endif
            end
            default:    rd_val_s = '0;
        endcase
    end

    // Control state: pointers, counts, mode, ready and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_wr_q      <= '0;
            a_rd_q      <= '0;
            b_wr_q      <= '0;
            b_rd_q      <= '0;
            y_wr_q      <= '0;
            y_rd_q      <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            y_cnt_q     <= '0;
            mode_q      <= 2'd0;
            rdy_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            rdy_q   <= 1'b1;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            y_cnt_q <= y_cnt_d;
            mode_q  <= mode_d;
            if (a_push_s)  a_wr_q <= a_wr_q + PTR_W'(1);
            if (b_push_s)  b_wr_q <= b_wr_q + PTR_W'(1);
            if (compute_s) begin
                a_rd_q <= a_rd_q + PTR_W'(1);
                b_rd_q <= b_rd_q + PTR_W'(1);
                y_wr_q <= y_wr_q + PTR_W'(1);
            end
            if (y_pop_s)   y_rd_q <= y_rd_q + PTR_W'(1);
            if (rd_acc_s)  read_data_q <= rd_val_s;
        end
    end

    // FIFO storage; contents are don't-care while the matching count is zero.
    always_ff @(posedge clk) begin
        if (a_push_s)  a_mem_q[a_wr_q] <= write_data;
        if (b_push_s)  b_mem_q[b_wr_q] <= write_data;
        if (compute_s) y_mem_q[y_wr_q] <= result_s;
    end

endmodule

// File: tb/tb_regif_alu_fifo.sv
// Self-checking bench for regif_alu_fifo: directed vector table plus randomized traffic
// checked against a queue-based reference model.
module tb_regif_alu_fifo;

    localparam int DW = 8;
    localparam int D  = 4;
`ifdef REGIF_ALU_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    write_address = 3'd0;
    logic [DW-1:0] write_data = 8'h00;
    logic          write_en = 1'b0;
    logic          write_rdy;
    logic [2:0]    read_address = 3'd0;
    logic          read_en = 1'b0;
    logic [DW-1:0] read_data;
    logic          read_rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regif_alu_fifo #(.DATA_W(DW), .FIFO_DEPTH(D), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [2:0] ra;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[$];

    // Reference model state
    logic [7:0] qa[$], qb[$], qy[$];
    logic [1:0] m_mode;
    logic [3:0] m_err;
    logic [7:0] m_last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_w(input logic [2:0] a, input logic [7:0] d);
        vec_t v;
        v = '{1'b1, a, d, 1'b0, 3'd0, 8'h00, "write"};
        tbl.push_back(v);
    endfunction

    function automatic void add_r(input logic [2:0] a, input logic [7:0] e, input string n);
        vec_t v;
        v = '{1'b0, 3'd0, 8'h00, 1'b1, a, e, n};
        tbl.push_back(v);
    endfunction

    function automatic void add_i();
        vec_t v;
        v = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, "idle"};
        tbl.push_back(v);
    endfunction

    function automatic logic [7:0] alu(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (m)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: begin
                s = (int'(a) + int'(b)) % 256;
                return 8'(s);
            end
        endcase
    endfunction

    function automatic void model_clear();
        qa.delete(); qb.delete(); qy.delete();
        m_mode = 2'd0; m_err = 4'd0; m_last_rd = 8'h00;
    endfunction

    // One clock of the specification's rules, all decisions from start-of-cycle state.
    function automatic void model_step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                       input logic re, input logic [2:0] ra);
        bit a_full, b_full, y_empty, comp;
        logic [7:0] rv, ha, hb;
        logic [3:0] ev;
        a_full  = (qa.size() == D);
        b_full  = (qb.size() == D);
        y_empty = (qy.size() == 0);
        comp    = (qa.size() > 0) && (qb.size() > 0) && (qy.size() < D);
        ev = 4'd0;
        case (ra)
            3'd0: rv = a_full ? 8'd0 : 8'd1;
            3'd1: rv = b_full ? 8'd0 : 8'd1;
            3'd2: rv = y_empty ? 8'd0 : 8'd1;
            3'd3: rv = y_empty ? 8'd0 : qy[0];
            3'd4: rv = 8'(qy.size());
            3'd6: rv = {6'd0, m_mode};
            3'd7: rv = ERR_EN ? {4'd0, m_err} : 8'd0;
            default: rv = 8'd0;
        endcase
        if (we) begin
            if (wa == 3'd4 && a_full) ev[0] = 1'b1;
            if (wa == 3'd5 && b_full) ev[1] = 1'b1;
            if (wa != 3'd4 && wa != 3'd5 && wa != 3'd6) ev[3] = 1'b1;
        end
        if (re && ra == 3'd3 && y_empty) ev[2] = 1'b1;
        if (re) begin
            m_last_rd = rv;
            if (ra == 3'd7) m_err = 4'd0;
            if (ra == 3'd3 && !y_empty) void'(qy.pop_front());
        end
        if (comp) begin
            ha = qa.pop_front();
            hb = qb.pop_front();
            qy.push_back(alu(m_mode, ha, hb));
        end
        if (we) begin
            if (wa == 3'd4 && !a_full) qa.push_back(wd);
            if (wa == 3'd5 && !b_full) qb.push_back(wd);
            if (wa == 3'd6) m_mode = wd[1:0];
        end
        if (ERR_EN) m_err = m_err | ev;
    endfunction

    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic re, input logic [2:0] ra, input bit use_model);
        write_en = we; write_address = wa; write_data = wd;
        read_en = re;  read_address = ra;
        if (use_model) model_step(we, wa, wd, re, ra);
        @(posedge clk); #1;
        write_en = 1'b0; read_en = 1'b0;
        if (use_model) chk("model_read_data", read_data, m_last_rd);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; write_en = 1'b0; read_en = 1'b0;
        #1;
        chk("async_rst_read_data", read_data, 0);
        chk("async_rst_rdy", {write_rdy, read_rdy}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rdy_low_before_edge", {write_rdy, read_rdy}, 0);
        @(posedge clk); #1;
        chk("rdy_high_after_edge", {write_rdy, read_rdy}, 2'b11);
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sweep_exp[3];
        logic [2:0] wa, ra;
        logic we, re;
        int r;
        sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hCC; sweep_exp[2] = 8'h2C;

        // Directed table
        add_r(3'd2, 8'h00, "reset_y_not_empty");
        add_r(3'd4, 8'h00, "reset_y_count");
        add_r(3'd6, 8'h00, "reset_mode");
        add_w(3'd4, 8'hA5); add_w(3'd5, 8'h0F); add_i();
        add_r(3'd2, 8'h01, "or_y_not_empty");
        add_r(3'd3, 8'hAF, "or_result");
        add_r(3'd4, 8'h00, "or_count_after_pop");
        for (int m = 1; m <= 3; m++) begin
            add_w(3'd6, 8'(m)); add_w(3'd4, 8'hF0); add_w(3'd5, 8'h3C); add_i();
            add_r(3'd3, sweep_exp[m-1], $sformatf("mode%0d_result", m));
        end
        add_r(3'd6, 8'h03, "mode_readback");
        add_w(3'd6, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            add_w(3'd4, 8'(k)); add_w(3'd5, 8'(k * 16));
        end
        add_r(3'd4, 8'h04, "full_y_count");
        add_r(3'd0, 8'h01, "full_a_not_full");
        add_r(3'd1, 8'h01, "full_b_not_full");
        add_r(3'd2, 8'h01, "full_y_not_empty");
        add_w(3'd4, 8'h06); add_w(3'd4, 8'h07); add_w(3'd4, 8'h08);
        add_r(3'd0, 8'h00, "a_full_status");
        add_w(3'd4, 8'h09);
        add_r(3'd7, ERR_EN ? 8'h01 : 8'h00, "err_a_drop");
        add_r(3'd7, 8'h00, "err_cleared");
        add_r(3'd3, 8'h11, "drain_0"); add_r(3'd3, 8'h22, "drain_1");
        add_r(3'd3, 8'h33, "drain_2"); add_r(3'd3, 8'h44, "drain_3");
        add_r(3'd3, 8'h55, "drain_refill");
        add_r(3'd3, 8'h00, "pop_empty");
        add_r(3'd4, 8'h00, "empty_count");
        add_r(3'd7, ERR_EN ? 8'h04 : 8'h00, "err_y_underflow");
        add_w(3'd1, 8'h55);
        add_r(3'd7, ERR_EN ? 8'h08 : 8'h00, "err_unmapped_write");
        add_r(3'd5, 8'h00, "unmapped_read");

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, 1'b0);
            if (tbl[i].re) chk(tbl[i].name, read_data, tbl[i].exp);
        end

        // Underflow, then 10 operand pairs with interleaved Y reads across pointer wrap
        do_reset();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1);
        step(1'b1, 3'd6, 8'h03, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'd4, 8'($urandom), 1'b1, 3'd3, 1'b1);
            step(1'b1, 3'd5, 8'($urandom), 1'b1, 3'd4, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1);
        chk("stream_drained", 32'(qy.size()), 0);

        // Randomized traffic on both ports
        for (int i = 0; i < 600; i++) begin
            we = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            wa = (r < 4) ? 3'd4 : (r < 8) ? 3'd5 : (r == 8) ? 3'd6 : 3'($urandom_range(0, 7));
            re = ($urandom_range(0, 2) != 0);
            ra = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            step(we, wa, 8'($urandom), re, ra, 1'b1);
        end

        // Reset in the middle of traffic discards everything
        step(1'b1, 3'd4, 8'h3A, 1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd5, 8'h5C, 1'b0, 3'd0, 1'b1);
        do_reset();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regif_alu_fifo.md
# regif_alu_fifo

Parametrised register-interface compute block. Two operand FIFOs (A, B) are filled through an address-mapped write port. The block applies a runtime-selectable bitwise/arithmetic operation and queues results in an output FIFO (Y), which software drains through an address-mapped read port. It generalises the fixed 1-bit, fixed-OR, depth-limited operand/result engine: configurable data width and FIFO depth, a mode register, a result count and optional sticky error reporting. It sits behind the testbench-facing wrapper as the DUT core.

## Interface
- DATA_W, 8: operand/result width in bits; must be >= 2.
- FIFO_DEPTH, 4: entries per FIFO (A, B, Y); power of two, 2..64.
- ADDR_W, 3: address width; fixed map below uses 0x0..0x7.
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_address  in  ADDR_W  write target.
- write_data  in  DATA_W  write payload.
- write_en  in  1  write request; accepted when write_en && write_rdy.
- write_rdy  out  1  write port ready.
- read_address  in  ADDR_W  read source.
- read_en  in  1  read request; accepted when read_en && read_rdy.
- read_data  out  DATA_W  registered read result.
- read_rdy  out  1  read port ready.

## Operation
- Write map:
  - 0x4 pushes A.
  - 0x5 pushes B.
  - 0x6 writes mode = write_data[1:0].
  - Other addresses are ignored.
- Read map, with status values zero-extended:
  - 0x0 = A not full.
  - 0x1 = B not full.
  - 0x2 = Y not empty.
  - 0x3 = pop Y, returning its head.
  - 0x4 = Y occupancy count.
  - 0x6 = mode.
  - 0x7 = error register (see Configuration).
  - Others return 0.
- Modes:
  - 0 OR.
  - 1 AND.
  - 2 XOR.
  - 3 ADD, computed modulo 2^DATA_W with carry discarded.
- Compute rule: when A and B are both non-empty and Y is not full (all judged at start of cycle), pop A and B and push op(A_head, B_head) into Y in the same cycle. The operation uses the mode value held at the start of the cycle.
- Write to a full A or B: dropped. The handshake still completes.
- Read of 0x3 with Y empty: returns 0, Y is unchanged.
- Full/empty are evaluated on start-of-cycle occupancy; there is no same-cycle bypass.
  - A write to a full A is dropped even if compute pops A that cycle.
  - A pop of Y and a compute push into Y may occur in the same cycle; occupancy then stays unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1, so a full FIFO reads count = FIFO_DEPTH.

## Timing
- Reset (reset_n low, asynchronous):
  - FIFOs empty, mode = 0.
  - read_data = 0, write_rdy = 0, read_rdy = 0.
  - Error register = 0.
- write_rdy and read_rdy are registered. They rise on the first clk edge after reset_n deasserts, then stay high.
- Write latency: a push accepted in cycle N is visible in status/count from cycle N+1. The earliest compute using it occurs in cycle N+1.
- Compute latency: operands pushed in cycle N produce a Y entry in cycle N+1. That entry is readable via 0x3 from cycle N+2.
- Read latency: an accepted read in cycle N drives read_data from cycle N+1. read_data holds its value until the next accepted read.
- Back-to-back accesses are supported on both ports every cycle, and the two ports operate independently.
- Reset asserted mid-operation discards all FIFO contents immediately. A transfer in flight is lost.

## Configuration
- Macro REGIF_ALU_ERR_EN.
- Defined: read address 0x7 returns a sticky error register, zero-extended. Bits:
  - bit0: A write dropped.
  - bit1: B write dropped.
  - bit2: Y read while empty.
  - bit3: write to an unmapped address.
- Bits set on the cycle after the event.
- An accepted read of 0x7 returns the current value and clears all bits. An event in the same cycle as that clearing read is retained (set wins).
- Not defined: address 0x7 reads 0, no error register is built, and error conditions are silent.

## Test plan
- Reset release: hold reset_n low 3 cycles, then release. Required: write_rdy/read_rdy go 1 one cycle after release; read 0x2 -> 0, read 0x4 -> 0, read 0x6 -> 0.
- OR path, DATA_W=8: write 0x4=0xA5, 0x5=0x0F. Required: read 0x2 -> 1, read 0x3 -> 0xAF, Y count then -> 0.
- Mode sweep with A=0xF0, B=0x3C: mode 1 -> 0x30, mode 2 -> 0xCC, mode 3 -> 0x2C (0x12C truncated to 8 bits).
- Full/backpressure, FIFO_DEPTH=4: push 5 A and 5 B without reading. Required:
  - Y count 4.
  - A and B each retain one entry; read 0x0 -> 1.
  - Push A to full, then the 5th A write is dropped; with REGIF_ALU_ERR_EN, read 0x7 -> 0x1, and a second read -> 0x0.
- Underflow/wrap: read 0x3 on empty Y -> 0 (error bit2 if enabled). Then stream 10 operand pairs with interleaved Y reads. Required: all 10 results are returned in order and are correct across pointer wrap.
